// File: rtl/issue_control_if.sv
// issue_control_if: instruction handshake, scoreboard request/response and issue bus of the issue stage.
interface issue_control_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  sb_id_op1;
    logic [4:0]  sb_id_op2;
    logic [4:0]  sb_id_dest;
    logic [6:0]  sb_op_code;
    logic        sb_new_line;
    logic        sb_pend_op1;
    logic        sb_pend_op2;
    logic        sb_pend_dest;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic [1:0]  issue_unit;
    logic        illegal;

    modport master (
        input  instr_valid, instr, sb_pend_op1, sb_pend_op2, sb_pend_dest,
        output instr_ready, sb_id_op1, sb_id_op2, sb_id_dest, sb_op_code, sb_new_line,
               issue_valid, issue_instr, issue_unit, illegal
    );

    modport slave (
        output instr_valid, instr, sb_pend_op1, sb_pend_op2, sb_pend_dest,
        input  instr_ready, sb_id_op1, sb_id_op2, sb_id_dest, sb_op_code, sb_new_line,
               issue_valid, issue_instr, issue_unit, illegal
    );
endinterface

// File: rtl/issue_control.sv
// issue_control: accept, scoreboard check and hazard-stalled issue of one instruction at a time.
// Define ISSUE_PERF_CNT_EN to build the issued_count performance counter (tied to 0 otherwise).
module issue_control #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    issue_control_if.master        bus,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [31:0]            issued_count
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_SW   = 7'b0100011;

    typedef enum logic [1:0] {IDLE, CHECK, EVAL} state_t;

    state_t      state;
    logic [31:0] held;
    logic [6:0]  op;
    logic        use1, use2, wrd, is_m, hazard, fire;

    assign op = held[6:0];

    always_comb begin
        use1   = op == OP_R || op == OP_ADDI || op == OP_LW || op == OP_BEQ || op == OP_SW;
        use2   = op == OP_R || op == OP_BEQ || op == OP_SW;
        wrd    = op == OP_R || op == OP_ADDI || op == OP_LW;
        is_m   = op == OP_LW || op == OP_SW;
        // rd pending is the WAW guard: an X write must not overtake an older 2-stage M write
        hazard = (use1 && held[19:15] != 5'd0 && bus.sb_pend_op1) ||
                 (use2 && held[24:20] != 5'd0 && bus.sb_pend_op2) ||
                 (wrd  && held[11:7]  != 5'd0 && bus.sb_pend_dest);
        fire   = state == EVAL && !hazard && !rst;
    end

    assign bus.sb_id_op1   = held[19:15];
    assign bus.sb_id_op2   = held[24:20];
    assign bus.sb_id_dest  = held[11:7];
    assign bus.sb_op_code  = op;
    assign bus.issue_instr = held;
    assign bus.issue_unit  = use1 ? (is_m ? 2'b10 : 2'b01) : 2'b00;
    assign bus.issue_valid = fire;
    assign bus.sb_new_line = fire && wrd && held[11:7] != 5'd0;
    assign bus.illegal     = fire && !use1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            held            <= '0;
            bus.instr_ready <= 1'b1;
            stall_cycles    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.instr_valid && bus.instr_ready) begin
                    held            <= bus.instr;
                    stall_cycles    <= '0;
                    bus.instr_ready <= 1'b0;
                    state           <= CHECK;
                end
                CHECK: state <= EVAL;
                EVAL: if (hazard) begin
                    stall_cycles <= stall_cycles != '1 ? stall_cycles + 1'b1 : stall_cycles;
                end else begin
                    bus.instr_ready <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) issued_count <= '0;
        else if (fire) issued_count <= issued_count + 32'd1;
    end
`else
    assign issued_count = '0;
`endif
endmodule

// File: tb/tb_issue_control.sv
// tb_issue_control: directed vectors for issue_control, built with a 3-bit stall counter to reach saturation.
module tb_issue_control;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  stall_cycles;
    logic [31:0] issued_count;
    int          tests = 0;
    int          fails = 0;
    int          issued = 0;
    int          n;

    issue_control_if bus();

    issue_control #(.STALL_CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .stall_cycles(stall_cycles),
        .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef ISSUE_PERF_CNT_EN
        return issued;
`else
        return 32'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pend(input logic [2:0] p);
        {bus.sb_pend_op1, bus.sb_pend_op2, bus.sb_pend_dest} = p;
    endtask

    task automatic accept(input logic [31:0] ins);
        bus.instr_valid = 1'b1;
        bus.instr = ins;
        step();
        bus.instr_valid = 1'b0;
        bus.instr = 32'hdead_beef;
        @(negedge clk);
        check("check_ready", bus.instr_ready, 0);
        check("check_issue", bus.issue_valid, 0);
        check("check_ids", {bus.sb_id_op1, bus.sb_id_op2, bus.sb_id_dest, bus.sb_op_code},
              {ins[19:15], ins[24:20], ins[11:7], ins[6:0]});
        step();
    endtask

    task automatic wait_issue(input int clr_after, input logic [2:0] keep, output int cnt);
        logic hit = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.issue_valid) begin
                hit = 1'b1;
                break;
            end
            cnt++;
            check("stall_ready", bus.instr_ready, 0);
            step();
            if (cnt == clr_after) set_pend(keep);
        end
        check("issue_seen", hit, 1);
        if (hit) issued++;
    endtask

    task automatic expect_issue(input logic [31:0] ins, input logic [1:0] unit, input logic nl,
                                input logic ill, input logic [2:0] st, input int cnt, input int exp_n);
        check("eval_cycles", cnt, exp_n);
        check("issue_instr", bus.issue_instr, ins);
        check("issue_unit", bus.issue_unit, unit);
        check("new_line", bus.sb_new_line, nl);
        check("illegal", bus.illegal, ill);
        check("stall_cycles", stall_cycles, st);
        check("dest_id", bus.sb_id_dest, ins[11:7]);
        check("ready_at_issue", bus.instr_ready, 0);
        step();
        @(negedge clk);
        check("post_new_line", bus.sb_new_line, 0);
        check("post_issue", bus.issue_valid, 0);
        check("post_ready", bus.instr_ready, 1);
        check("post_stall", stall_cycles, st);
        check("issued_count", issued_count, exp_cnt());
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        set_pend(3'b000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.instr_ready, 1);
        check("rst_issue", {bus.issue_valid, bus.sb_new_line, bus.illegal}, 0);
        check("rst_ids", {bus.sb_id_op1, bus.sb_id_op2, bus.sb_id_dest, bus.sb_op_code}, 0);
        check("rst_instr", bus.issue_instr, 0);
        check("rst_unit", bus.issue_unit, 0);
        check("rst_stall", stall_cycles, 0);
        check("rst_count", issued_count, 0);

        // add x3,x1,x2 with no hazard: issue two cycles after accept
        accept(32'h002081B3);
        wait_issue(100, 3'b000, n);
        expect_issue(32'h002081B3, 2'b01, 1'b1, 1'b0, 3'd0, n, 0);

        // lw x5 waits on a pending destination for 4 EVAL cycles
        set_pend(3'b001);
        accept(32'h0000A283);
        wait_issue(4, 3'b000, n);
        expect_issue(32'h0000A283, 2'b10, 1'b1, 1'b0, 3'd4, n, 4);

        // sw stalls on rs2 only; a pending rd field is ignored
        set_pend(3'b011);
        accept(32'h0020A3A3);
        wait_issue(3, 3'b001, n);
        expect_issue(32'h0020A3A3, 2'b10, 1'b0, 1'b0, 3'd3, n, 3);

        // addi x0,x0,1 never stalls and never reserves
        set_pend(3'b111);
        accept(32'h00100013);
        wait_issue(100, 3'b111, n);
        expect_issue(32'h00100013, 2'b01, 1'b0, 1'b0, 3'd0, n, 0);

        // unsupported opcode issues straight away as illegal
        accept(32'h1234507F);
        wait_issue(100, 3'b111, n);
        expect_issue(32'h1234507F, 2'b00, 1'b0, 1'b1, 3'd0, n, 0);

        // beq stalls on rs1, ignores rd pending
        set_pend(3'b101);
        accept(32'h00208063);
        wait_issue(2, 3'b001, n);
        expect_issue(32'h00208063, 2'b01, 1'b0, 1'b0, 3'd2, n, 2);

        // 10 stall cycles saturate the 3-bit counter at 7
        set_pend(3'b001);
        accept(32'h0000A303);
        wait_issue(10, 3'b000, n);
        expect_issue(32'h0000A303, 2'b10, 1'b1, 1'b0, 3'd7, n, 10);

        // reset while stalling in EVAL drops the instruction
        set_pend(3'b100);
        accept(32'h002081B3);
        repeat (2) begin
            @(negedge clk);
            check("pre_rst_issue", bus.issue_valid, 0);
            step();
        end
        rst = 1'b1;
        set_pend(3'b000);
        @(negedge clk);
        check("rst_cycle_issue", bus.issue_valid, 0);
        check("rst_cycle_new_line", bus.sb_new_line, 0);
        step();
        rst = 1'b0;
        issued = 0;
        @(negedge clk);
        check("after_rst_ready", bus.instr_ready, 1);
        check("after_rst_stall", stall_cycles, 0);
        check("after_rst_instr", bus.issue_instr, 0);
        check("after_rst_count", issued_count, 0);
        repeat (3) begin
            step();
            @(negedge clk);
            check("dropped_issue", {bus.issue_valid, bus.sb_new_line}, 0);
            check("idle_ready", bus.instr_ready, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/issue_control.md
# issue_control

Issue-stage controller for the i2o2 pipeline; it is the initiator that drives the `scoreboard` block. It accepts one decoded instruction at a time over a valid/ready handshake and presents its register ids to the scoreboard. It then waits for the scoreboard's registered pending flags and stalls while any RAW or WAW hazard is pending. Once clear, it issues the instruction and pulses `new_line` so the scoreboard reserves the destination.

## Interface
Parameters:
- STALL_CNT_W, 16, width of the saturating per-instruction stall counter `stall_cycles`.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_valid  in  1  upstream offers `instr`.
- instr  in  32  RV32 instruction word.
- instr_ready  out  1  controller can accept; transfer when valid&&ready at a clock edge.
- sb_id_op1 / sb_id_op2 / sb_id_dest  out  5  = held instr[19:15] / [24:20] / [11:7].
- sb_op_code  out  7  = held instr[6:0].
- sb_new_line  out  1  one-cycle reservation pulse to the scoreboard.
- sb_pend_op1 / sb_pend_op2 / sb_pend_dest  in  1  registered pending flags from the scoreboard.
- issue_valid  out  1  one-cycle pulse; `issue_instr` and `issue_unit` are valid.
- issue_instr  out  32  issued instruction.
- issue_unit  out  2  01 = X (ALU), 10 = M (memory), 00 = unsupported.
- illegal  out  1  pulses with `issue_valid` when the opcode is unsupported.
- stall_cycles  out  STALL_CNT_W  EVAL cycles spent stalled on the current or last instruction; saturating.
- issued_count  out  32  instructions issued since reset (see Configuration).

## Operation
- Opcode classes (uses rs1 / rs2 / writes rd / unit):
  - R-type 0110011: yes / yes / yes / X.
  - addi 0010011: yes / no / yes / X.
  - lw 0000011: yes / no / yes / M.
  - beq 1100011: yes / yes / no / X.
  - sw 0100011: yes / yes / no / M.
  - Any other opcode: no / no / no / unit 00, `illegal`=1.
- Hazard = (uses rs1 && rs1≠0 && sb_pend_op1) || (uses rs2 && rs2≠0 && sb_pend_op2) || (writes rd && rd≠0 && sb_pend_dest).
- The rd check is the WAW guard. M completes in 2 stages and X in 1, so a younger X write could otherwise retire before an older M write.
- `sb_new_line` pulses only for instructions that write rd with rd≠0. beq, sw, x0 writes and illegal opcodes never reserve an entry.
- States:
  - IDLE: instr_ready=1. On valid&&ready, latch instr and go to CHECK.
  - CHECK: ids driven; one wait cycle for the scoreboard's registered outputs. Go to EVAL.
  - EVAL: if hazard, stay in EVAL and increment stall_cycles. Otherwise assert issue_valid for this cycle (plus sb_new_line when applicable) and go to IDLE.
- stall_cycles clears when an instruction is accepted, then holds its final value after issue until the next accept.
- The held instruction and the sb_id_* outputs remain stable from accept through issue. They hold their last value in IDLE.

## Timing
- Reset values: state IDLE; instr_ready=1 in the cycle after reset; issue_valid, sb_new_line, illegal = 0; sb_id_*, sb_op_code, issue_instr, issue_unit = 0; stall_cycles = 0; issued_count = 0.
- Hazard-free latency: accept edge T, then CHECK in cycle T+1, then issue_valid in cycle T+2. Minimum 3 cycles per instruction.
- instr_ready is 0 in CHECK and EVAL, and is never asserted in the same cycle as issue_valid.
- sb_new_line is 1 for exactly one cycle. Between consecutive pulses it is low for at least 2 cycles, which guarantees an edge for the scoreboard's level-change trigger.
- stall_cycles saturates at 2^STALL_CNT_W−1; it does not wrap.
- rst asserted in any state: next cycle is IDLE with reset values. A held instruction is dropped without issue, and no sb_new_line pulse is emitted in the reset cycle.

## Configuration
- ISSUE_PERF_CNT_EN defined: issued_count increments by 1 on every issue_valid cycle, including illegal issues, and wraps modulo 2^32.
- ISSUE_PERF_CNT_EN undefined: the counter logic is not compiled and issued_count is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then offer add x3,x1,x2 (0x002081B3) with all pend=0: issue_valid in cycle accept+2, issue_unit=01, sb_new_line=1 with sb_id_dest=3, stall_cycles=0.
- lw x5 accepted while sb_pend_dest=1 for 4 EVAL cycles, then 0: exactly 4 stall cycles, issue on the 5th EVAL cycle, stall_cycles=4, issue_unit=10.
- sw with rs2 pending, rd field=7 while sb_pend_dest=1: stalls only while sb_pend_op2=1, ignores sb_pend_dest, issues with sb_new_line=0.
- addi x0,x0,1 with all sb_pend_*=1: no stall, issue_valid=1, sb_new_line=0.
- Opcode 0x7F: issues immediately after CHECK with issue_unit=00, illegal=1, sb_new_line=0. With ISSUE_PERF_CNT_EN defined, issued_count increments; without it, issued_count stays 0.
- rst asserted during EVAL while stalling: next cycle IDLE, instr_ready=1, no issue_valid or sb_new_line ever emitted for the dropped instruction, stall_cycles=0.
